spi_reg_bridge: RTL

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

---
 rtl/spi_reg_bridge.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: bridges an SPI peripheral's async strobes onto a single-beat register bus.
// Ports: clk_i/rst_n_i (sync, active low); SPI side cs_i, per_addr_i, per_data_i, per_wr_i,
//   per_wr_done_o, per_req_i, per_data_o, per_rd_o; register bus bus_addr_o, bus_wdata_o,
//   bus_we_o, bus_re_o, bus_rdata_i, bus_ack_i.
// Option: define SPI_BRIDGE_TIMEOUT_EN to complete a bus cycle after TIMEOUT_CYCLES without ack
//   (reads then return 8'hFF, writes still report done).
module spi_reg_bridge #(
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255,
  parameter logic [15:0] FIFO_BASE      = 16'h0024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cs_i,
  input  logic [15:0] per_addr_i,
  input  logic [7:0]  per_data_i,
  input  logic        per_wr_i,
  output logic        per_wr_done_o,
  input  logic        per_req_i,
  output logic [7:0]  per_data_o,
  output logic        per_rd_o,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_wdata_o,
  output logic        bus_we_o,
  output logic        bus_re_o,
  input  logic [7:0]  bus_rdata_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_HOLD} state_t;

  state_t      state_q, state_d;
  // [0],[1] synchronizer, [2] history for edge detection
  logic [2:0]  cs_sh_q, cs_sh_d;
  logic [2:0]  wr_sh_q, wr_sh_d;
  logic [2:0]  rq_sh_q, rq_sh_d;
  logic [1:0]  off_q, off_d;
  logic        pend_q, pend_d;
  logic        abort_q, abort_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic [7:0]  pdata_q, pdata_d;
  logic        prd_q, prd_d;
  logic        done_q, done_d;
`ifdef SPI_BRIDGE_TIMEOUT_EN
  logic [7:0]  tmo_q, tmo_d;
  logic        tmo_hit;
`endif

  logic        cs_sync, cs_rise;
  logic        wr_rise;
  logic        rq_sync, rq_rise;
  logic        in_fifo;
  logic [15:0] tgt_addr;
  logic        done_tx;
  logic        discard;
  logic [7:0]  rdat;

  assign cs_sync = cs_sh_q[1];
  assign cs_rise = cs_sh_q[1] & ~cs_sh_q[2];
  assign wr_rise = wr_sh_q[1] & ~wr_sh_q[2];
  assign rq_sync = rq_sh_q[1];
  assign rq_rise = rq_sh_q[1] & ~rq_sh_q[2];

  // FIFO window addresses are non-incrementing
  assign in_fifo  = (per_addr_i - FIFO_BASE) < 16'd4;
  assign tgt_addr = in_fifo ? per_addr_i
                            : per_addr_i + {14'd0, off_q};

  // a cs rise during the bus cycle drops its result
  assign discard = abort_q | cs_rise;

  always_comb begin
    done_tx = bus_ack_i;
    rdat    = bus_rdata_i;
`ifdef SPI_BRIDGE_TIMEOUT_EN
    tmo_hit = ({1'b0, tmo_q} + 9'd1) >= {1'b0, TIMEOUT_CYCLES};
    if (!bus_ack_i && tmo_hit) begin
      done_tx = 1'b1;
      rdat    = 8'hFF;
    end
`endif
  end

  always_comb begin
    cs_sh_d = {cs_sh_q[1:0], cs_i};
    wr_sh_d = {wr_sh_q[1:0], per_wr_i};
    rq_sh_d = {rq_sh_q[1:0], per_req_i};
    state_d = state_q;
    off_d   = off_q;
    pend_d  = pend_q;
    abort_d = abort_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    re_d    = re_q;
    pdata_d = pdata_q;
    prd_d   = prd_q;
    done_d  = 1'b0;
`ifdef SPI_BRIDGE_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif

    unique case (state_q)
      IDLE: begin
`ifdef SPI_BRIDGE_TIMEOUT_EN
        tmo_d = 8'd0;
`endif
        abort_d = 1'b0;
        if (wr_rise) begin
          state_d = WR;
          addr_d  = tgt_addr;
          wdata_d = per_data_i;
          we_d    = 1'b1;
          if (rq_rise) pend_d = 1'b1;
        end else if (rq_rise || pend_q) begin
          state_d = RD;
          addr_d  = tgt_addr;
          re_d    = 1'b1;
          pend_d  = 1'b0;
        end
      end
      WR: begin
`ifdef SPI_BRIDGE_TIMEOUT_EN
        tmo_d = tmo_q + 8'd1;
`endif
        if (rq_rise) pend_d = 1'b1;
        if (cs_rise) abort_d = 1'b1;
        if (done_tx) begin
          we_d    = 1'b0;
          state_d = IDLE;
          if (!discard) begin
            done_d = 1'b1;
            off_d  = off_q + 2'd1;
          end
        end
      end
      RD: begin
`ifdef SPI_BRIDGE_TIMEOUT_EN
        tmo_d = tmo_q + 8'd1;
`endif
        if (cs_rise) abort_d = 1'b1;
        if (done_tx) begin
          re_d = 1'b0;
          if (discard) begin
            state_d = IDLE;
          end else begin
            pdata_d = rdat;
            prd_d   = 1'b1;
            off_d   = off_q + 2'd1;
            state_d = RD_HOLD;
          end
        end
      end
      RD_HOLD: begin
        if (!rq_sync) begin
          prd_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cs_sync) begin
      off_d  = 2'd0;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cs_sh_q <= 3'd0;
      wr_sh_q <= 3'd0;
      rq_sh_q <= 3'd0;
      off_q   <= 2'd0;
      pend_q  <= 1'b0;
      abort_q <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 8'd0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      pdata_q <= 8'h00;
      prd_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SPI_BRIDGE_TIMEOUT_EN
      tmo_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cs_sh_q <= cs_sh_d;
      wr_sh_q <= wr_sh_d;
      rq_sh_q <= rq_sh_d;
      off_q   <= off_d;
      pend_q  <= pend_d;
      abort_q <= abort_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      pdata_q <= pdata_d;
      prd_q   <= prd_d;
      done_q  <= done_d;
`ifdef SPI_BRIDGE_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus_addr_o    = addr_q;
  assign bus_wdata_o   = wdata_q;
  assign bus_we_o      = we_q;
  assign bus_re_o      = re_q;
  assign per_data_o    = pdata_q;
  assign per_rd_o      = prd_q;
  assign per_wr_done_o = done_q;

endmodule
